// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide unit: one bit per cycle on a shared add/sub,
// owns HI/LO and services MTHI/MTLO while idle.
module muldiv_seq #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         abort,
  input  logic         wr_hi,
  input  logic         wr_lo,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned W2 = 2 * N;
  localparam int unsigned WS = N + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic [N-1:0]  mag_b_q, mag_b_d;
  logic [W2-1:0] acc_q, acc_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic          done_q, done_d;

  logic          sa_in_c, sb_in_c;
  logic [N-1:0]  mag_a_in_c, mag_b_in_c;
  logic [WS-1:0] x_c, y_c, as_c;
  logic [W2-1:0] step_c;
  logic [W2-1:0] prod_c;
  logic [N-1:0]  quo_c, rem_c;
  logic [N-1:0]  res_hi_c, res_lo_c;

  // Operand capture: signed ops work on magnitudes, signs kept aside
  assign sa_in_c    = op[0] & a[N-1];
  assign sb_in_c    = op[0] & b[N-1];
  assign mag_a_in_c = sa_in_c ? -a : a;
  assign mag_b_in_c = sb_in_c ? -b : b;

  // Shared adder: acc_hi + b for multiply, {acc_hi, next dividend bit} - b for divide
  always_comb begin
    x_c = '0;
    y_c = '0;
    if (is_div_q) begin
      x_c = {1'b0, acc_q[W2-1:N], acc_q[N-1]};
      y_c = ~{2'b00, mag_b_q};
    end else begin
      x_c = {2'b00, acc_q[W2-1:N]};
      y_c = {2'b00, mag_b_q};
    end
    as_c = x_c + y_c + WS'(is_div_q);
  end

  // One iteration: shift-add multiply or restoring divide step
  always_comb begin
    step_c = acc_q;
    if (is_div_q) begin
      if (!as_c[WS-1]) step_c = {as_c[N-1:0], acc_q[N-2:0], 1'b1};
      else             step_c = {x_c[N-1:0], acc_q[N-2:0], 1'b0};
    end else begin
      if (acc_q[0]) step_c = {as_c[N:0], acc_q[N-1:1]};
      else          step_c = {1'b0, acc_q[W2-1:N], acc_q[N-1:1]};
    end
  end

  // Sign correction of the finished result
  always_comb begin
    prod_c   = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_c    = acc_q[N-1:0];
    rem_c    = acc_q[W2-1:N];
    res_hi_c = prod_c[W2-1:N];
    res_lo_c = prod_c[N-1:0];
    if (is_div_q) begin
      res_hi_c = sa_q ? -rem_c : rem_c;
      if (mag_b_q == '0)    res_lo_c = '1;
      else if (sa_q ^ sb_q) res_lo_c = -quo_c;
      else                  res_lo_c = quo_c;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = wdata;
        if (wr_lo) lo_d = wdata;
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          is_div_d = op[1];
          sa_d     = sa_in_c;
          sb_d     = sb_in_c;
          mag_b_d  = mag_b_in_c;
          acc_d    = {{N{1'b0}}, mag_a_in_c};
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_c;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!abort) begin
          hi_d   = res_hi_c;
          lo_d   = res_lo_c;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: multiply/divide results, latency, abort,
// MTHI/MTLO interaction and asynchronous reset.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  muldiv_seq #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and return at the cycle after busy drops (the done cycle)
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic ab, output int cyc);
    op = o; a = x; b = y; abort = ab; start = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    abort = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    #14 rst_n = 1'b1;
    step();
  endtask

  task automatic test_multu_max();
    int cyc;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", cyc); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL multu_done: got %b want 1", done); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, cyc);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done: got %b want 1", done); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    // DIV issued in the done cycle must be accepted
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL div_b2b_cycles: got %0d want 33", cyc); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    step();
  endtask

  task automatic test_div_special();
    int cyc;
    run_op(OP_DIVU, 32'd100, 32'd0, 1'b0, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL divu0_cycles: got %0d want 33", cyc); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo: got %h want ffffffff", lo); end
    checks++; if (hi !== 32'h0000_0064) begin errors++; $display("FAIL divu0_hi: got %h want 00000064", hi); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divovf_hi: got %h want 00000000", hi); end
    run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0, cyc);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_neg_lo: got %h want ffffffff", lo); end
    checks++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div0_neg_hi: got %h want fffffffb", hi); end
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b0, cyc);
    checks++; if (lo !== 32'h0FFF_FFFF) begin errors++; $display("FAIL divu_big_lo: got %h want 0fffffff", lo); end
    checks++; if (hi !== 32'h0000_000F) begin errors++; $display("FAIL divu_big_hi: got %h want 0000000f", hi); end
    step();
  endtask

  task automatic test_abort();
    int cyc;
    wr_hi = 1'b1; wdata = 32'h1234; step();
    wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h5678; step();
    wr_lo = 1'b0;
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi: got %h want 00001234", hi); end
    checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo: got %h want 00005678", lo); end
    op = OP_DIVU; a = 32'd50; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      // second start during RUN must be ignored
      if (i == 3) begin op = OP_MULTU; a = 32'd3; b = 32'd3; start = 1'b1; end
      step();
      start = 1'b0;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
    abort = 1'b1; step(); abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done_late: got %b want 0", done); end
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL abort_hi: got %h want 00001234", hi); end
    checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL abort_lo: got %h want 00005678", lo); end
    // abort while in FIX beats the result write
    op = OP_DIVU; a = 32'd50; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (32) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fix_busy: got %b want 1", busy); end
    abort = 1'b1; step(); abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fix_abort_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL fix_abort_done: got %b want 0", done); end
    checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL fix_abort_lo: got %h want 00005678", lo); end
    // abort in IDLE does not block start
    run_op(OP_DIVU, 32'd50, 32'd7, 1'b1, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL idle_abort_cycles: got %0d want 33", cyc); end
    checks++; if (lo !== 32'd7) begin errors++; $display("FAIL idle_abort_lo: got %h want 00000007", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL idle_abort_hi: got %h want 00000001", hi); end
    step();
  endtask

  task automatic test_busy_writes();
    int cyc;
    op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    wr_hi = 1'b1; wdata = 32'h99;
    step();
    start = 1'b0; wr_hi = 1'b0;
    checks++; if (hi !== 32'h99) begin errors++; $display("FAIL start_mthi: got %h want 00000099", hi); end
    cyc = 1;
    while (busy && cyc < 100) begin
      if (cyc == 5) begin wr_lo = 1'b1; wdata = 32'hAAAA; end
      if (cyc == 8) begin start = 1'b1; a = 32'd100; b = 32'd100; end
      step();
      wr_lo = 1'b0; start = 1'b0;
      if (busy) cyc++;
    end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL bw_cycles: got %0d want 33", cyc); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bw_done: got %b want 1", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL bw_hi: got %h want 00000000", hi); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL bw_lo: got %h want 0000002a", lo); end
    step();
  endtask

  task automatic test_reset_mid();
    int cyc;
    wr_hi = 1'b1; wdata = 32'hBEEF; step(); wr_hi = 1'b0;
    op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h want 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h want 00000000", lo); end
    #3 rst_n = 1'b1;
    step();
    run_op(OP_MULTU, 32'd6, 32'd7, 1'b0, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL rst_after_cycles: got %0d want 33", cyc); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL rst_after_lo: got %h want 0000002a", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_after_hi: got %h want 00000000", hi); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_back_to_back();
    test_div_special();
    test_abort();
    test_busy_writes();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
